// File: rtl/b200_atr_pkg.sv
// Shared definitions for the B200 ATR sequencer: per-radio FSM states and
// frontend GPIO bit positions (fe_gpio is {tx_enable .. LED_TXRX_TX}, MSB first).
package b200_atr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_RX           = 3'd1,
    ST_TX_ON_GUARD  = 3'd2,
    ST_TX           = 3'd3,
    ST_TX_OFF_GUARD = 3'd4
  } atr_state_t;

  localparam int FE_TX_ENABLE   = 7;
  localparam int FE_SFDX_RX     = 6;
  localparam int FE_SFDX_TX     = 5;
  localparam int FE_SRX_RX      = 4;
  localparam int FE_SRX_TX      = 3;
  localparam int FE_LED_RX      = 2;
  localparam int FE_LED_TXRX_RX = 1;
  localparam int FE_LED_TXRX_TX = 0;

  localparam logic [7:0] FE_LED_MASK = 8'h07;

  function automatic logic is_tx_path(input atr_state_t s);
    return (s == ST_TX_ON_GUARD) || (s == ST_TX) || (s == ST_TX_OFF_GUARD);
  endfunction

endpackage

// File: rtl/b200_atr_chan_fsm.sv
// One radio's ATR sequencer: state machine, guard counter and next-cycle GPIO decode.
// LED bits are driven only when B200_ATR_LED_EN is defined; otherwise they read 0.
module b200_atr_chan_fsm
  import b200_atr_pkg::*;
#(
  parameter int GUARD_W = 8
) (
  input  logic               radio_clk,
  input  logic               radio_rst_n,
  input  logic               atr_rx,
  input  logic               atr_tx,
  input  logic               rx_ant_sel,
  input  logic [GUARD_W-1:0] guard_cycles,
  output logic [7:0]         gpio_nxt,
  output logic               pa_nxt
);

  atr_state_t         state_p0;
  logic [GUARD_W-1:0] cnt_p0;

  function automatic logic [7:0] decode_gpio(input atr_state_t s, input logic rx,
                                             input logic ant);
    logic [7:0] g;
    g = 8'h00;
    if (s == ST_RX) begin
      if (ant) begin
        g[FE_SFDX_RX]     = 1'b1;
        g[FE_LED_TXRX_RX] = 1'b1;
      end else begin
        g[FE_SRX_RX] = 1'b1;
        g[FE_LED_RX] = 1'b1;
      end
    end else if (is_tx_path(s)) begin
      g[FE_SFDX_TX]     = 1'b1;
      g[FE_LED_TXRX_TX] = 1'b1;
      g[FE_TX_ENABLE]   = (s == ST_TX);
      // Full duplex keeps the receiver on the RX2 port while transmitting.
      if (rx) begin
        g[FE_SRX_RX] = 1'b1;
        g[FE_LED_RX] = 1'b1;
      end
    end
`ifdef B200_ATR_LED_EN
    return g;
`else
    return g & ~FE_LED_MASK;
`endif
  endfunction

  // Stage p0: state and guard counter
  always_ff @(posedge radio_clk) begin
    if (!radio_rst_n) begin
      state_p0 <= ST_IDLE;
      cnt_p0   <= '0;
    end else begin
      case (state_p0)
        ST_IDLE, ST_RX: begin
          if (atr_tx) begin
            state_p0 <= ST_TX_ON_GUARD;
            cnt_p0   <= guard_cycles;
          end else begin
            state_p0 <= atr_rx ? ST_RX : ST_IDLE;
          end
        end
        ST_TX_ON_GUARD: begin
          if (!atr_tx)             state_p0 <= atr_rx ? ST_RX : ST_IDLE;
          else if (cnt_p0 == '0)   state_p0 <= ST_TX;
          else                     cnt_p0   <= cnt_p0 - 1'b1;
        end
        ST_TX: begin
          if (!atr_tx) begin
            state_p0 <= ST_TX_OFF_GUARD;
            cnt_p0   <= guard_cycles;
          end
        end
        ST_TX_OFF_GUARD: begin
          // A re-request skips the rest of the off-guard; switches never left TX.
          if (atr_tx)              state_p0 <= ST_TX;
          else if (cnt_p0 == '0)   state_p0 <= atr_rx ? ST_RX : ST_IDLE;
          else                     cnt_p0   <= cnt_p0 - 1'b1;
        end
        default: begin
          state_p0 <= ST_IDLE;
          cnt_p0   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    gpio_nxt = decode_gpio(state_p0, atr_rx, rx_ant_sel);
    pa_nxt   = (state_p0 == ST_TX);
  end

endmodule

// File: rtl/b200_atr_seq.sv
// B200 ATR sequencer top: two per-radio FSMs, frontend swap and registered outputs.
// Optional macro B200_ATR_LED_EN enables the frontend LED bits.
module b200_atr_seq
  import b200_atr_pkg::*;
#(
  parameter int GUARD_W = 8
) (
  input  logic               radio_clk,
  input  logic               radio_rst_n,
  input  logic [1:0]         atr_rx,
  input  logic [1:0]         atr_tx,
  input  logic [1:0]         rx_ant_sel,
  input  logic [GUARD_W-1:0] guard_cycles,
  input  logic               swap_atr_n,
  output logic [7:0]         fe0_gpio,
  output logic [7:0]         fe1_gpio,
  output logic [1:0]         pa_on
);

  logic [7:0] gpio_nxt [2];
  logic [1:0] pa_nxt;
  logic [7:0] fe0_gpio_p1;
  logic [7:0] fe1_gpio_p1;
  logic [1:0] pa_on_p1;

  for (genvar r = 0; r < 2; r++) begin : g_chan
    b200_atr_chan_fsm #(
      .GUARD_W (GUARD_W)
    ) u_chan (
      .radio_clk    (radio_clk),
      .radio_rst_n  (radio_rst_n),
      .atr_rx       (atr_rx[r]),
      .atr_tx       (atr_tx[r]),
      .rx_ant_sel   (rx_ant_sel[r]),
      .guard_cycles (guard_cycles),
      .gpio_nxt     (gpio_nxt[r]),
      .pa_nxt       (pa_nxt[r])
    );
  end

  // Stage p1: frontend routing and output registers; swap only re-routes, FSMs unaffected
  always_ff @(posedge radio_clk) begin
    if (!radio_rst_n) begin
      fe0_gpio_p1 <= 8'h00;
      fe1_gpio_p1 <= 8'h00;
      pa_on_p1    <= 2'b00;
    end else begin
      fe0_gpio_p1 <= swap_atr_n ? gpio_nxt[1] : gpio_nxt[0];
      fe1_gpio_p1 <= swap_atr_n ? gpio_nxt[0] : gpio_nxt[1];
      pa_on_p1    <= pa_nxt;
    end
  end

  assign fe0_gpio = fe0_gpio_p1;
  assign fe1_gpio = fe1_gpio_p1;
  assign pa_on    = pa_on_p1;

endmodule

// File: tb/tb_b200_atr_seq.sv
// Scoreboard bench for b200_atr_seq: behavioural per-radio model feeds an expected
// queue each clock; a negedge monitor compares. Directed scenarios then random traffic.
module tb_b200_atr_seq;

  localparam int GUARD_W = 8;
`ifdef B200_ATR_LED_EN
  localparam bit LED_ON = 1'b1;
`else
  localparam bit LED_ON = 1'b0;
`endif

  logic               radio_clk = 1'b0;
  logic               radio_rst_n = 1'b0;
  logic [1:0]         atr_rx = 2'b00;
  logic [1:0]         atr_tx = 2'b00;
  logic [1:0]         rx_ant_sel = 2'b00;
  logic [GUARD_W-1:0] guard_cycles = '0;
  logic               swap_atr_n = 1'b0;
  logic [7:0]         fe0_gpio;
  logic [7:0]         fe1_gpio;
  logic [1:0]         pa_on;

  int errors = 0;
  int checks = 0;

  b200_atr_seq #(.GUARD_W(GUARD_W)) dut (
    .radio_clk    (radio_clk),
    .radio_rst_n  (radio_rst_n),
    .atr_rx       (atr_rx),
    .atr_tx       (atr_tx),
    .rx_ant_sel   (rx_ant_sel),
    .guard_cycles (guard_cycles),
    .swap_atr_n   (swap_atr_n),
    .fe0_gpio     (fe0_gpio),
    .fe1_gpio     (fe1_gpio),
    .pa_on        (pa_on)
  );

  always #5 radio_clk = ~radio_clk;

  typedef struct packed {
    logic [7:0] fe0;
    logic [7:0] fe1;
    logic [1:0] pa;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: each radio is quiet (remembering whether it was receiving),
  // ramping up, transmitting or ramping down, with a count of guard cycles left.
  localparam int QUIET = 0, RAMP_UP = 1, ON_AIR = 2, RAMP_DOWN = 3;
  int phase [2] = '{QUIET, QUIET};
  int left  [2] = '{0, 0};
  bit rxq   [2] = '{1'b0, 1'b0};

  function automatic logic [7:0] model_gpio(input int ph, input bit was_rx, input bit rx_now,
                                            input bit ant);
    int v;
    v = 0;
    if (ph == QUIET) begin
      if (was_rx) v = ant ? (8'h40 + 8'h02) : (8'h10 + 8'h04);
    end else begin
      v = 8'h20 + 8'h01;
      if (ph == ON_AIR) v += 8'h80;
      if (rx_now) v += 8'h10 + 8'h04;
    end
    if (!LED_ON) v = v - (v % 8);
    return v[7:0];
  endfunction

  always @(posedge radio_clk) begin
    exp_t e;
    logic [7:0] g [2];
    for (int r = 0; r < 2; r++) g[r] = model_gpio(phase[r], rxq[r], atr_rx[r], rx_ant_sel[r]);
    if (!radio_rst_n) begin
      e = '0;
    end else begin
      e.fe0 = swap_atr_n ? g[1] : g[0];
      e.fe1 = swap_atr_n ? g[0] : g[1];
      e.pa  = {phase[1] == ON_AIR, phase[0] == ON_AIR};
    end
    exp_q.push_back(e);
    for (int r = 0; r < 2; r++) begin
      if (!radio_rst_n) begin
        phase[r] = QUIET; left[r] = 0; rxq[r] = 1'b0;
      end else begin
        case (phase[r])
          QUIET: begin
            if (atr_tx[r]) begin phase[r] = RAMP_UP; left[r] = int'(guard_cycles); end
            else rxq[r] = atr_rx[r];
          end
          RAMP_UP: begin
            if (!atr_tx[r]) begin phase[r] = QUIET; rxq[r] = atr_rx[r]; end
            else if (left[r] == 0) phase[r] = ON_AIR;
            else left[r]--;
          end
          ON_AIR: begin
            if (!atr_tx[r]) begin phase[r] = RAMP_DOWN; left[r] = int'(guard_cycles); end
          end
          default: begin
            if (atr_tx[r]) phase[r] = ON_AIR;
            else if (left[r] == 0) begin phase[r] = QUIET; rxq[r] = atr_rx[r]; end
            else left[r]--;
          end
        endcase
      end
    end
  end

  always @(negedge radio_clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_fe0", fe0_gpio, e.fe0);
      check("sb_fe1", fe1_gpio, e.fe1);
      check("sb_pa", {6'b0, pa_on}, {6'b0, e.pa});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge radio_clk);
  endtask

  initial begin
    logic [7:0] fdx;
    fdx = LED_ON ? 8'hB5 : 8'hB0;

    tick(3);
    check("rst_fe0", fe0_gpio, 8'h00);
    check("rst_fe1", fe1_gpio, 8'h00);
    check("rst_pa", {6'b0, pa_on}, 8'h00);
    radio_rst_n = 1'b1;
    tick(2);

    // Turn-on with guard 4; a mid-count guard change must not matter
    guard_cycles = 8'd4;
    atr_tx = 2'b01;
    tick(2);
    check("on_sfdx_tx", {7'b0, fe0_gpio[5]}, 8'h01);
    check("on_txen_early", {7'b0, fe0_gpio[7]}, 8'h00);
    guard_cycles = 8'd9;
    tick(4);
    check("on_txen_guard", {7'b0, fe0_gpio[7]}, 8'h00);
    tick(1);
    check("on_txen", {7'b0, fe0_gpio[7]}, 8'h01);
    check("on_pa", {6'b0, pa_on}, 8'h01);
    guard_cycles = 8'd4;
    tick(3);

    // Turn-off with guard 4
    atr_tx = 2'b00;
    tick(2);
    check("off_txen", {7'b0, fe0_gpio[7]}, 8'h00);
    check("off_sfdx", {7'b0, fe0_gpio[5]}, 8'h01);
    tick(4);
    check("off_sfdx_hold", {7'b0, fe0_gpio[5]}, 8'h01);
    tick(1);
    check("off_idle", fe0_gpio, 8'h00);

    // Abort during the on-guard
    atr_tx = 2'b01;
    tick(3);
    atr_tx = 2'b00;
    for (int i = 0; i < 6; i++) check("abort_no_txen", {7'b0, fe0_gpio[7]}, 8'h00);
    tick(6);
    check("abort_idle", fe0_gpio, 8'h00);

    // Full duplex with TX/RX antenna selected
    atr_rx = 2'b01;
    rx_ant_sel = 2'b01;
    atr_tx = 2'b01;
    tick(8);
    check("fdx_fe0", fe0_gpio, fdx);
    check("fdx_fe1", fe1_gpio, 8'h00);

    // Swap while transmitting
    swap_atr_n = 1'b1;
    tick(1);
    check("swap_fe1", fe1_gpio, fdx);
    check("swap_fe0", fe0_gpio, 8'h00);
    check("swap_pa", {6'b0, pa_on}, 8'h01);

    // Reset during TX
    radio_rst_n = 1'b0;
    tick(1);
    check("midtx_rst_fe0", fe0_gpio, 8'h00);
    check("midtx_rst_fe1", fe1_gpio, 8'h00);
    check("midtx_rst_pa", {6'b0, pa_on}, 8'h00);
    radio_rst_n = 1'b1;
    swap_atr_n = 1'b0;
    atr_rx = 2'b00;
    tick(2);
    check("post_rst_on", {7'b0, fe0_gpio[5]}, 8'h01);
    check("post_rst_txen", {7'b0, fe0_gpio[7]}, 8'h00);

    // Zero guard on radio 1
    atr_tx = 2'b10;
    guard_cycles = 8'd0;
    tick(8);
    atr_tx = 2'b00;
    tick(6);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) atr_tx[0] = ~atr_tx[0];
      if ($urandom_range(0, 7) == 0) atr_tx[1] = ~atr_tx[1];
      if ($urandom_range(0, 5) == 0) atr_rx = 2'($urandom);
      if ($urandom_range(0, 19) == 0) rx_ant_sel = 2'($urandom);
      if ($urandom_range(0, 15) == 0) guard_cycles = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 39) == 0) swap_atr_n = ~swap_atr_n;
      radio_rst_n = ($urandom_range(0, 299) != 0);
      tick(1);
    end
    radio_rst_n = 1'b1;
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/b200_atr_seq.md
B200_ATR_SEQ -- requirements
Module: b200_atr_seq

Interface
REQ-001 SHALL have parameter GUARD_W, default 8: width of the guard-interval counter and of guard_cycles.
REQ-002 SHALL have port radio_clk, input, 1: the only clock; every flop samples on its rising edge.
REQ-003 SHALL have port radio_rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port atr_rx, input, 2: per-radio receive-active; bit n belongs to radio n.
REQ-005 SHALL have port atr_tx, input, 2: per-radio transmit-request; bit n belongs to radio n.
REQ-006 SHALL have port rx_ant_sel, input, 2: per-radio RX antenna; 0 = RX2 port, 1 = TX/RX port.
REQ-007 SHALL have port guard_cycles, input, GUARD_W: switch-settle interval in radio_clk cycles.
REQ-008 SHALL have port swap_atr_n, input, 1: 1 routes radio1 to fe0 and radio0 to fe1; 0 routes straight.
REQ-009 SHALL have port fe0_gpio, output, 8: frontend-0 controls {tx_enable, SFDX_RX, SFDX_TX, SRX_RX, SRX_TX, LED_RX, LED_TXRX_RX, LED_TXRX_TX}, MSB first.
REQ-010 SHALL have port fe1_gpio, output, 8: frontend-1 controls, same bit order as fe0_gpio.
REQ-011 SHALL have port pa_on, output, 2: per-radio status; 1 while that radio's FSM is in TX.

Function
REQ-012 SHALL run one independent FSM per radio with states IDLE, RX, TX_ON_GUARD, TX, TX_OFF_GUARD.
REQ-013 SHALL, in IDLE or RX: go to TX_ON_GUARD and load counter = guard_cycles when atr_tx=1; else go to RX when atr_rx=1, else IDLE.
REQ-014 SHALL, in TX_ON_GUARD: go to TX when counter==0 and decrement otherwise; go to RX or IDLE (per atr_rx) at once if atr_tx drops.
REQ-015 SHALL, in TX: go to TX_OFF_GUARD and load counter = guard_cycles when atr_tx=0.
REQ-016 SHALL, in TX_OFF_GUARD: return to TX at once if atr_tx reasserts; otherwise go to RX or IDLE (per atr_rx) when counter==0, decrementing until then.
REQ-017 SHALL sample guard_cycles only at counter load; a change during a count SHALL NOT affect that count.
REQ-018 SHALL, when guard_cycles=0, still pass through each guard state for exactly one cycle.
REQ-019 SHALL drive IDLE as all control bits 0.
REQ-020 SHALL drive RX as SRX_RX=1, LED_RX=1 when rx_ant_sel=0, or as SFDX_RX=1, LED_TXRX_RX=1 when rx_ant_sel=1.
REQ-021 SHALL drive all three TX-path states as SFDX_TX=1 and LED_TXRX_TX=1; tx_enable=1 in TX only.
REQ-022 SHALL, in any TX-path state with atr_rx=1 (full duplex), also drive SRX_RX=1 and LED_RX=1, regardless of rx_ant_sel.
REQ-023 SHALL register fe0_gpio, fe1_gpio and pa_on, so an output reflects the state entered one clock earlier; latency from an atr edge to a switch change is 2 cycles.
REQ-024 SHALL guarantee tx_enable=1 only after the TX-path switches have been held for guard_cycles+1 cycles, and switches stay in the TX path for guard_cycles+1 cycles after tx_enable drops.
REQ-025 SHALL apply swap_atr_n in the output register stage; a swap change SHALL take effect on the next edge and SHALL NOT disturb FSM state.

Reset
REQ-026 SHALL, when radio_rst_n=0 at an edge, force both FSMs to IDLE, both counters to 0, fe0_gpio=fe1_gpio=8'h00 and pa_on=2'b00.
REQ-027 SHALL, if reset occurs mid-TX, drop tx_enable on the same edge, with no off-guard.

Configuration
REQ-028 SHALL, when macro B200_ATR_LED_EN is defined, drive the LED bits per REQ-019..022; when it is undefined, tie the LED bits to 0 and leave all other bits unchanged.

Structure
REQ-029 SHALL place the state encodings and the fe_gpio bit-index constants in shared package b200_atr_pkg.
REQ-030 SHALL implement one FSM plus counter as sub-module b200_atr_chan_fsm, instantiated twice; swap and output registers stay in the top.

Verification
REQ-031 SHALL cover: reset, then atr_tx[0]=1 with guard_cycles=4, swap_atr_n=0 -> fe0 SFDX_TX=1 two cycles later, tx_enable=1 five cycles after that, pa_on[0]=1 alongside.
REQ-032 SHALL cover: in TX, atr_tx[0]=0 with guard=4 -> tx_enable=0 two cycles later; SFDX_TX stays 1 five more cycles, then fe0_gpio=8'h00.
REQ-033 SHALL cover: atr_tx drops at guard count 2 of TX_ON_GUARD -> tx_enable never asserts; state goes to IDLE.
REQ-034 SHALL cover: atr_rx=1, atr_tx=1, rx_ant_sel=1 -> after the guard, fe_gpio=8'b1_0110_1_01 (LED_EN defined); without B200_ATR_LED_EN -> 8'b1_0110_0_00.
REQ-035 SHALL cover: radio0 in TX, swap_atr_n toggled 0->1 -> the TX pattern moves from fe0 to fe1 on the next edge; pa_on is unchanged.
REQ-036 SHALL cover: radio_rst_n=0 during TX -> all outputs 0 on that edge; after release, FSM starts from IDLE.
